// File: rtl/mipi_periph_tx_arbiter.sv
// Round-robin arbiter sharing the MIPI peripheral TX command channel between the
// read-response path (0) and the ack/error report path (1); one transfer per BTA.
module mipi_periph_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter logic [1:0]  VC          = 2'd0
) (
  input  logic        clk_periph,
  input  logic        rstn,
  input  logic [1:0]  req,
  input  logic [11:0] req_data_type,
  input  logic [31:0] req_byte_count,
  input  logic [63:0] req_payload,
  output logic [1:0]  gnt,
  output logic [1:0]  payload_pop,
  output logic [1:0]  done,
  output logic        timeout_err,
  output logic        bta_miss,
  input  logic        mipi_periph_dphy_direction,
  output logic        mipi_periph_tx_cmd_req,
  input  logic        mipi_periph_tx_cmd_ack,
  output logic [1:0]  mipi_periph_tx_cmd_vc,
  output logic [5:0]  mipi_periph_tx_cmd_data_type,
  output logic [15:0] mipi_periph_tx_cmd_byte_count,
  output logic [31:0] mipi_periph_tx_payload,
  input  logic        mipi_periph_tx_payload_en,
  input  logic        mipi_periph_tx_payload_en_last
);

  typedef enum logic [1:0] {IDLE, REQ, PAYLOAD} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_nx;
  logic        dir_d, dir_dd, bta;
  logic [1:0]  gnt_nx, done_nx;
  logic        cmd_req_nx, tmo_nx, miss_nx;
  logic [5:0]  dt_nx;
  logic [15:0] bc_nx;
  logic        last_q, last_nx;
  logic [15:0] cnt_q, cnt_nx;
  logic        pick, is_short, tmo_hit;

  assign bta      = dir_dd & ~dir_d;
  // last_q holds the index served most recently; only consulted when both are pending
  assign pick     = (req == 2'b11) ? ~last_q : req[1];
  assign is_short = (mipi_periph_tx_cmd_data_type == 6'h02) ||
                    (mipi_periph_tx_cmd_data_type == 6'h21) ||
                    (mipi_periph_tx_cmd_data_type == 6'h22);
  assign tmo_hit  = (cnt_q == TMO_LAST);

  assign mipi_periph_tx_cmd_vc  = VC;
  assign payload_pop            = (state == PAYLOAD && mipi_periph_tx_payload_en) ? gnt : 2'b00;
  assign mipi_periph_tx_payload = gnt[1] ? req_payload[63:32] :
                                  gnt[0] ? req_payload[31:0]  : 32'd0;

  always_comb begin
    state_nx   = state;
    gnt_nx     = gnt;
    cmd_req_nx = mipi_periph_tx_cmd_req;
    done_nx    = 2'b00;
    tmo_nx     = 1'b0;
    miss_nx    = 1'b0;
    dt_nx      = mipi_periph_tx_cmd_data_type;
    bc_nx      = mipi_periph_tx_cmd_byte_count;
    last_nx    = last_q;
    cnt_nx     = cnt_q + 16'd1;
    case (state)
      IDLE: begin
        cnt_nx = 16'd0;
        if (bta) begin
          if (req != 2'b00) begin
            gnt_nx     = pick ? 2'b10 : 2'b01;
            dt_nx      = pick ? req_data_type[11:6]   : req_data_type[5:0];
            bc_nx      = pick ? req_byte_count[31:16] : req_byte_count[15:0];
            cmd_req_nx = 1'b1;
            state_nx   = REQ;
          end else begin
            miss_nx = 1'b1;
          end
        end
      end
      REQ: begin
        miss_nx = bta;
        if (mipi_periph_tx_cmd_ack) begin
          cmd_req_nx = 1'b0;
          if (is_short) begin
            done_nx  = gnt;
            gnt_nx   = 2'b00;
            last_nx  = gnt[1];
            state_nx = IDLE;
          end else begin
            cnt_nx   = 16'd0;
            state_nx = PAYLOAD;
          end
        end else if (tmo_hit) begin
          cmd_req_nx = 1'b0;
          tmo_nx     = 1'b1;
          gnt_nx     = 2'b00;
          state_nx   = IDLE;
        end
      end
      PAYLOAD: begin
        miss_nx = bta;
        if (mipi_periph_tx_payload_en && mipi_periph_tx_payload_en_last) begin
          done_nx  = gnt;
          gnt_nx   = 2'b00;
          last_nx  = gnt[1];
          state_nx = IDLE;
        end else if (tmo_hit) begin
          tmo_nx   = 1'b1;
          gnt_nx   = 2'b00;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_periph or negedge rstn) begin
    if (!rstn) begin
      state                         <= IDLE;
      dir_d                         <= 1'b0;
      dir_dd                        <= 1'b0;
      gnt                           <= 2'b00;
      done                          <= 2'b00;
      timeout_err                   <= 1'b0;
      bta_miss                      <= 1'b0;
      mipi_periph_tx_cmd_req        <= 1'b0;
      mipi_periph_tx_cmd_data_type  <= 6'd0;
      mipi_periph_tx_cmd_byte_count <= 16'd0;
      last_q                        <= 1'b1;
      cnt_q                         <= 16'd0;
    end else begin
      state                         <= state_nx;
      dir_d                         <= mipi_periph_dphy_direction;
      dir_dd                        <= dir_d;
      gnt                           <= gnt_nx;
      done                          <= done_nx;
      timeout_err                   <= tmo_nx;
      bta_miss                      <= miss_nx;
      mipi_periph_tx_cmd_req        <= cmd_req_nx;
      mipi_periph_tx_cmd_data_type  <= dt_nx;
      mipi_periph_tx_cmd_byte_count <= bc_nx;
      last_q                        <= last_nx;
      cnt_q                         <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_mipi_periph_tx_arbiter.sv
// Directed bench for mipi_periph_tx_arbiter: short/long packets, round-robin, timeout, BTA misses, reset.
module tb_mipi_periph_tx_arbiter;

  logic        clk_periph = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [11:0] req_data_type = 12'd0;
  logic [31:0] req_byte_count = 32'd0;
  logic [63:0] req_payload = 64'd0;
  logic [1:0]  gnt, payload_pop, done;
  logic        timeout_err, bta_miss;
  logic        direction = 1'b1;
  logic        cmd_req;
  logic        cmd_ack = 1'b0;
  logic [1:0]  cmd_vc;
  logic [5:0]  cmd_dt;
  logic [15:0] cmd_bc;
  logic [31:0] tx_payload;
  logic        pl_en = 1'b0;
  logic        pl_last = 1'b0;

  int errors = 0;
  int checks = 0;
  logic miss_seen;

  mipi_periph_tx_arbiter #(.TIMEOUT_CYC(4096), .VC(2'd0)) dut (
    .clk_periph                    (clk_periph),
    .rstn                          (rstn),
    .req                           (req),
    .req_data_type                 (req_data_type),
    .req_byte_count                (req_byte_count),
    .req_payload                   (req_payload),
    .gnt                           (gnt),
    .payload_pop                   (payload_pop),
    .done                          (done),
    .timeout_err                   (timeout_err),
    .bta_miss                      (bta_miss),
    .mipi_periph_dphy_direction    (direction),
    .mipi_periph_tx_cmd_req        (cmd_req),
    .mipi_periph_tx_cmd_ack        (cmd_ack),
    .mipi_periph_tx_cmd_vc         (cmd_vc),
    .mipi_periph_tx_cmd_data_type  (cmd_dt),
    .mipi_periph_tx_cmd_byte_count (cmd_bc),
    .mipi_periph_tx_payload        (tx_payload),
    .mipi_periph_tx_payload_en     (pl_en),
    .mipi_periph_tx_payload_en_last(pl_last)
  );

  always #5 clk_periph = ~clk_periph;

  task automatic step();
    @(posedge clk_periph);
    #1;
    if (bta_miss) miss_seen = 1'b1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; req = 2'b00; cmd_ack = 1'b0; pl_en = 1'b0; pl_last = 1'b0; direction = 1'b1;
    step(); step();
    rstn = 1'b1;
    step(); step();
    miss_seen = 1'b0;
  endtask

  // direction held high two edges, then falls; returns just after the FSM reacts
  task automatic bta();
    direction = 1'b1; step(); step();
    direction = 1'b0; step(); step();
    direction = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; #1;
    checks++;
    if ({gnt, payload_pop, done, timeout_err, bta_miss, cmd_req, cmd_vc, cmd_dt, cmd_bc, tx_payload} !== '0) begin
      errors++; $display("FAIL reset_outputs: gnt=%b pop=%b done=%b req=%b dt=%h bc=%h, want all 0", gnt, payload_pop, done, cmd_req, cmd_dt, cmd_bc);
    end
    do_reset();
  endtask

  task automatic test_short();
    do_reset();
    req = 2'b01; req_data_type = {6'h00, 6'h21}; req_byte_count = {16'h0000, 16'h0081};
    direction = 1'b0; step();
    checks++;
    if (cmd_req !== 1'b0) begin errors++; $display("FAIL short_req_early: cmd_req=%b want 0", cmd_req); end
    step(); direction = 1'b1;
    checks++;
    if ({cmd_req, gnt, cmd_dt, cmd_bc} !== {1'b1, 2'b01, 6'h21, 16'h0081}) begin
      errors++; $display("FAIL short_cmd: req=%b gnt=%b dt=%h bc=%h want 1 01 21 0081", cmd_req, gnt, cmd_dt, cmd_bc);
    end
    req_data_type = 12'h0; req_byte_count = 32'h0;
    cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
    checks++;
    if ({done, gnt, cmd_req} !== {2'b01, 2'b00, 1'b0}) begin
      errors++; $display("FAIL short_done: done=%b gnt=%b req=%b want 01 00 0", done, gnt, cmd_req);
    end
    step();
    checks++;
    if (done !== 2'b00) begin errors++; $display("FAIL short_done_pulse: done=%b want 00", done); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [3];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    do_reset();
    req = 2'b11; req_data_type = {6'h22, 6'h02}; req_byte_count = {16'hBEEF, 16'h1234};
    for (int k = 0; k < 3; k++) begin
      bta();
      checks++;
      if ({gnt, cmd_req} !== {exp_g[k], 1'b1}) begin
        errors++; $display("FAIL rr_gnt%0d: gnt=%b req=%b want %b 1", k, gnt, cmd_req, exp_g[k]);
      end
      cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
      checks++;
      if (done !== exp_g[k]) begin errors++; $display("FAIL rr_done%0d: done=%b want %b", k, done, exp_g[k]); end
    end
    checks++;
    if (miss_seen !== 1'b0) begin errors++; $display("FAIL rr_bta_miss: seen=%b want 0", miss_seen); end
  endtask

  task automatic test_long();
    logic [31:0] words [3];
    int pops;
    words[0] = 32'hA5A5_0001; words[1] = 32'h5A5A_0002; words[2] = 32'hDEAD_0003;
    pops = 0;
    do_reset();
    req = 2'b10; req_data_type = {6'h1C, 6'h21}; req_byte_count = {16'h000A, 16'h0005};
    bta();
    checks++;
    if ({gnt, cmd_dt, cmd_bc} !== {2'b10, 6'h1C, 16'h000A}) begin
      errors++; $display("FAIL long_cmd: gnt=%b dt=%h bc=%h want 10 1c 000a", gnt, cmd_dt, cmd_bc);
    end
    cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
    checks++;
    if ({cmd_req, done, gnt} !== {1'b0, 2'b00, 2'b10}) begin
      errors++; $display("FAIL long_payload_entry: req=%b done=%b gnt=%b want 0 00 10", cmd_req, done, gnt);
    end
    // last without en must be ignored
    pl_last = 1'b1; step(); pl_last = 1'b0;
    checks++;
    if ({done, gnt} !== {2'b00, 2'b10}) begin
      errors++; $display("FAIL long_last_no_en: done=%b gnt=%b want 00 10", done, gnt);
    end
    for (int k = 0; k < 3; k++) begin
      req_payload = {words[k], ~words[k]};
      pl_en = 1'b1; pl_last = (k == 2); #1;
      if (payload_pop == 2'b10) pops++;
      checks++;
      if (tx_payload !== words[k]) begin
        errors++; $display("FAIL long_word%0d: tx_payload=%h want %h", k, tx_payload, words[k]);
      end
      step(); pl_en = 1'b0; pl_last = 1'b0;
      if (k < 2) begin
        #1;
        if (payload_pop != 2'b00) pops++;
        step();
      end
    end
    checks++;
    if (pops !== 3) begin errors++; $display("FAIL long_pop_count: pops=%0d want 3", pops); end
    checks++;
    if ({done, gnt} !== {2'b10, 2'b00}) begin
      errors++; $display("FAIL long_done: done=%b gnt=%b want 10 00", done, gnt);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req = 2'b01; req_data_type = {6'h00, 6'h02}; req_byte_count = 32'h0000_0042;
    bta();
    n = 0;
    while (timeout_err !== 1'b1 && n < 5000) begin
      step(); n++;
    end
    checks++;
    if (n !== 4096) begin errors++; $display("FAIL tmo_cycles: got %0d want 4096", n); end
    checks++;
    if ({cmd_req, gnt, done} !== {1'b0, 2'b00, 2'b00}) begin
      errors++; $display("FAIL tmo_state: req=%b gnt=%b done=%b want 0 00 00", cmd_req, gnt, done);
    end
    step();
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse: timeout_err=%b want 0", timeout_err); end
    bta();
    checks++;
    if ({cmd_req, gnt} !== {1'b1, 2'b01}) begin
      errors++; $display("FAIL tmo_reserve: req=%b gnt=%b want 1 01", cmd_req, gnt);
    end
    cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
    checks++;
    if (done !== 2'b01) begin errors++; $display("FAIL tmo_reserve_done: done=%b want 01", done); end
  endtask

  task automatic test_bta_miss();
    do_reset();
    req = 2'b00;
    bta();
    checks++;
    if ({bta_miss, cmd_req, gnt} !== {1'b1, 1'b0, 2'b00}) begin
      errors++; $display("FAIL miss_idle: miss=%b req=%b gnt=%b want 1 0 00", bta_miss, cmd_req, gnt);
    end
    step();
    checks++;
    if (bta_miss !== 1'b0) begin errors++; $display("FAIL miss_pulse: miss=%b want 0", bta_miss); end
    req = 2'b01; req_data_type = {6'h00, 6'h1C}; req_byte_count = 32'h0000_0004;
    bta();
    cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
    bta();
    checks++;
    if ({bta_miss, gnt} !== {1'b1, 2'b01}) begin
      errors++; $display("FAIL miss_payload: miss=%b gnt=%b want 1 01", bta_miss, gnt);
    end
    pl_en = 1'b1; pl_last = 1'b1; step(); pl_en = 1'b0; pl_last = 1'b0;
    checks++;
    if ({done, gnt} !== {2'b01, 2'b00}) begin
      errors++; $display("FAIL miss_payload_done: done=%b gnt=%b want 01 00", done, gnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b01; req_data_type = {6'h00, 6'h1C}; req_byte_count = 32'h0000_0008;
    req_payload = 64'h1111_2222_3333_4444;
    bta();
    cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
    pl_en = 1'b1; #2;
    rstn = 1'b0; #1;
    checks++;
    if ({gnt, payload_pop, done, timeout_err, bta_miss, cmd_req, cmd_vc, cmd_dt, cmd_bc, tx_payload} !== '0) begin
      errors++; $display("FAIL rst_mid: gnt=%b pop=%b req=%b dt=%h pl=%h want all 0", gnt, payload_pop, cmd_req, cmd_dt, tx_payload);
    end
    pl_en = 1'b0;
    step(); rstn = 1'b1; step(); step();
    bta();
    checks++;
    if ({cmd_req, gnt, cmd_dt} !== {1'b1, 2'b01, 6'h1C}) begin
      errors++; $display("FAIL rst_mid_reserve: req=%b gnt=%b dt=%h want 1 01 1c", cmd_req, gnt, cmd_dt);
    end
  endtask

  initial begin
    miss_seen = 1'b0;
    test_reset();
    test_short();
    test_round_robin();
    test_long();
    test_timeout();
    test_bta_miss();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
